dt_scan_ctrl: RTL and testbench
===============================

DT_SCAN_CTRL -- requirements
Module: dt_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter PRESCALE, default 3000, clk cycles per sub-tick (legal minimum 2).
REQ-003 SHALL have parameter SEG_ACT_LOW, default 1; segment and dp outputs are active-low when 1.
REQ-004 SHALL have parameter EN_ACT_LOW, default 1; digit enables are active-low when 1.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port load  in  1  one-cycle strobe that captures num_in and dp_in.
REQ-008 SHALL have port num_in  in  4*DIGITS  hex nibble per digit; nibble 0 is the least-significant (rightmost) digit.
REQ-009 SHALL have port dp_in  in  DIGITS  decimal point per digit.
REQ-010 SHALL have port blank_lz  in  1  leading-zero blanking enable.
REQ-011 SHALL have port bright  in  4  brightness level 0..15.
REQ-012 SHALL have port ds_en  out  DIGITS  digit enables.
REQ-013 SHALL have port ds_reg  out  7  segments {g,f,e,d,c,b,a}.
REQ-014 SHALL have port ds_dp  out  1  decimal point.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-016 SHALL generate a sub-tick every PRESCALE clk cycles from a free-running prescaler.
REQ-017 SHALL make each digit slot 16 sub-ticks long, with sub-tick counter sub running 0..15.
REQ-018 SHALL scan digit index 0,1,...,DIGITS-1 and wrap to 0 when sub wraps 15->0.
REQ-019 SHALL hold a shadow register (nibbles, dp) loaded on load=1 and set a pending flag.
REQ-020 SHALL copy shadow to the active register at the frame boundary (last digit, sub 15->0) when pending=1, then clear pending.
REQ-021 SHALL, when load and the frame boundary coincide, transfer the old shadow, capture the new data into shadow, and leave pending=1.
REQ-022 SHALL pulse frame_done for exactly one cycle at each frame boundary, whether or not a transfer occurs.
REQ-023 SHALL drive the current digit's ds_en active only when 1 <= sub <= bright; all other ds_en bits and sub=0 are inactive (ghosting guard).
REQ-024 SHALL keep ds_en fully dark when bright=0, and at 15/16 duty when bright=15.
REQ-025 SHALL sample bright at the start of each slot (sub=0) and hold it for that slot.
REQ-026 SHALL update ds_reg and ds_dp only at sub=0, registered, one cycle after the sub-tick.
REQ-027 SHALL decode hex to segments (active-high form): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-028 SHALL blank segments (dp unaffected) for digit k>0 when blank_lz=1, nibble k=0, and all nibbles above k are 0; digit 0 is never blanked.
REQ-029 SHALL invert segment/dp outputs per SEG_ACT_LOW and enable outputs per EN_ACT_LOW.

Reset
REQ-030 SHALL, while rst_n=0, clear prescaler, sub, digit index, shadow, active register, and pending.
REQ-031 SHALL, while rst_n=0, hold frame_done=0, all ds_en inactive, and ds_reg/ds_dp in the "off" level.
REQ-032 SHALL, after reset release, begin the scan at digit 0, sub 0, displaying active value 0.
REQ-033 SHALL, on reset assertion mid-frame, take effect immediately, discarding pending data.

Verification (PRESCALE=2, DIGITS=4, active-low both)
REQ-034 SHALL cover: reset -> ds_en=4'b1111, ds_reg=7'b1111111, ds_dp=1, frame_done=0.
REQ-035 SHALL cover: load num_in=16'h12AF, bright=15 -> after next frame_done, digit 0 shows ds_reg=~7'b1110001 and digit 3 shows ~7'b0000110; frame period = 4*16*2 = 128 cycles.
REQ-036 SHALL cover: num_in=16'h0050, blank_lz=1 -> digits 3 and 2 read ds_reg=7'b1111111, digit 1 reads ~1101101, digit 0 reads ~0111111.
REQ-037 SHALL cover: bright=4 -> each ds_en bit low for exactly 4 sub-ticks (8 cycles) per 32-cycle slot; bright=0 -> ds_en stays 4'b1111.
REQ-038 SHALL cover: load asserted on the frame-boundary cycle -> old shadow is displayed for one frame, new value after the following frame_done.
REQ-039 SHALL cover: rst_n low mid-frame with pending=1 -> outputs return to their reset levels asynchronously, and after release the display shows 0.

Source files
------------

// File: rtl/dt_scan_ctrl.sv
// dt_scan_ctrl: multiplexed hex display scanner with double-buffered data,
// per-slot PWM brightness, leading-zero blanking and a frame-done pulse.
module dt_scan_ctrl #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned PRESCALE    = 3000,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          EN_ACT_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   num_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     ds_en,
   output logic [6:0]            ds_reg,
   output logic                  ds_dp,
   output logic                  frame_done
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned NW = 4 * DIGITS;

   logic [PW-1:0]     pre_q;
   logic [3:0]        sub_q;
   logic [DW-1:0]     dig_q;
   logic [3:0]        bright_q;
   logic [NW-1:0]     sh_num_q;
   logic [DIGITS-1:0] sh_dp_q;
   logic [NW-1:0]     act_num_q;
   logic [DIGITS-1:0] act_dp_q;
   logic              pend_q;

   logic              tick_c;
   logic              last_dig_c;
   logic              boundary_c;
   logic [3:0]        nib_c;
   logic              dpb_c;
   logic [DIGITS-1:0] zfrom_c;
   logic              blank_c;
   logic [6:0]        seg_c;
   logic [DIGITS-1:0] en_c;

   // Hex nibble to active-high segments {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   assign tick_c     = (pre_q == PW'(PRESCALE - 1));
   assign last_dig_c = (dig_q == DW'(DIGITS - 1));
   assign boundary_c = tick_c && (sub_q == 4'd15) && last_dig_c;

   // Free-running prescaler, one sub-tick every PRESCALE cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pre_q <= '0;
      else if (tick_c) pre_q <= '0;
      else             pre_q <= pre_q + PW'(1);
   end

   // Sub-tick counter within a slot and digit index across the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= '0;
         dig_q <= '0;
      end else if (tick_c) begin
         sub_q <= sub_q + 4'd1;
         if (sub_q == 4'd15) dig_q <= last_dig_c ? '0 : dig_q + DW'(1);
      end
   end

   // Shadow capture on load; shadow-to-active transfer at the frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_num_q  <= '0;
         sh_dp_q   <= '0;
         act_num_q <= '0;
         act_dp_q  <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (boundary_c && pend_q) begin
            act_num_q <= sh_num_q;
            act_dp_q  <= sh_dp_q;
         end
         if (load) begin
            sh_num_q <= num_in;
            sh_dp_q  <= dp_in;
         end
         if (load)            pend_q <= 1'b1;
         else if (boundary_c) pend_q <= 1'b0;
      end
   end

   // Brightness is held for the slot; only its sub=0 value matters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              bright_q <= '0;
      else if (sub_q == 4'd0)  bright_q <= bright;
   end

   // Current digit's nibble, dp, and leading-zero blank decision
   always_comb begin
      logic run;
      nib_c   = '0;
      dpb_c   = 1'b0;
      zfrom_c = '0;
      run     = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         run        = run & (act_num_q[4*i +: 4] == 4'd0);
         zfrom_c[i] = run;
      end
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (dig_q == DW'(k)) begin
            nib_c = act_num_q[4*k +: 4];
            dpb_c = act_dp_q[k];
         end
      end
      blank_c = blank_lz && (dig_q != '0) && zfrom_c[dig_q];
      seg_c   = blank_c ? 7'd0 : hex7(nib_c);
   end

   // Enable window: current digit only, for sub-ticks 1..bright
   always_comb begin
      en_c = '0;
      if ((sub_q != 4'd0) && (sub_q <= bright_q)) en_c = DIGITS'(1) << dig_q;
   end

   // Registered display outputs and frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ds_en      <= {DIGITS{EN_ACT_LOW}};
         ds_reg     <= {7{SEG_ACT_LOW}};
         ds_dp      <= SEG_ACT_LOW;
         frame_done <= 1'b0;
      end else begin
         ds_en      <= en_c ^ {DIGITS{EN_ACT_LOW}};
         frame_done <= boundary_c;
         if (sub_q == 4'd0) begin
            ds_reg <= seg_c ^ {7{SEG_ACT_LOW}};
            ds_dp  <= dpb_c ^ SEG_ACT_LOW;
         end
      end
   end

endmodule

// File: tb/tb_dt_scan_ctrl.sv
// tb_dt_scan_ctrl: randomized frame-level stimulus with a scoreboard of
// pending display updates and a monitor that checks every enable window.
module tb_dt_scan_ctrl;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned PRESCALE = 2;
   localparam int          SLOT     = 16 * PRESCALE;
   localparam int          FRAME    = DIGITS * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] num_in = '0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bright = '0;
   logic [3:0]  ds_en;
   logic [6:0]  ds_reg;
   logic        ds_dp;
   logic        frame_done;

   always #5 clk = ~clk;

   dt_scan_ctrl #(
      .DIGITS(DIGITS), .PRESCALE(PRESCALE), .SEG_ACT_LOW(1'b1), .EN_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .num_in(num_in), .dp_in(dp_in),
      .blank_lz(blank_lz), .bright(bright), .ds_en(ds_en), .ds_reg(ds_reg),
      .ds_dp(ds_dp), .frame_done(frame_done)
   );

   typedef struct {
      int          idx;
      logic [15:0] val;
      logic [3:0]  dp;
   } upd_t;

   upd_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          fcount = 0;
   logic [15:0] exp_val = '0;
   logic [3:0]  exp_dp = '0;
   int          exp_bright = 0;
   bit          exp_blank = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
            7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
            7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
      return t[n];
   endfunction

   // Expected active-high segments of digit d for the value now on display
   function automatic logic [6:0] exp_seg(input int d);
      logic [15:0] v;
      v = exp_val;
      if (exp_blank && d > 0 && (v >> (4 * d)) == 16'd0) return 7'd0;
      return hex7(v[4*d +: 4]);
   endfunction

   // Monitor: checks each enable window, frame period and scoreboard updates
   initial begin : monitor
      int         off, offn, wlen, wdig, wbright, frame_bright, win_cnt;
      bit         in_win;
      logic [3:0] en_a;
      logic [6:0] seg_a;
      logic       dp_a;
      off = -1; wlen = 0; wdig = 0; wbright = 0; frame_bright = 0; win_cnt = 0; in_win = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            off = -1; in_win = 0; win_cnt = 0; fcount = 0; frame_bright = 0;
            continue;
         end
         offn  = off + 1;
         en_a  = ~ds_en;
         seg_a = ~ds_reg;
         dp_a  = ~ds_dp;
         if (en_a != 4'd0) begin
            if (!in_win) begin
               in_win  = 1;
               wlen    = 0;
               wbright = frame_bright;
               win_cnt++;
               wdig = 0;
               for (int k = 0; k < 4; k++) if (en_a[k]) wdig = k;
               chk("window_start_offset", offn, SLOT * wdig + 3);
            end
            wlen++;
            chk("en_onehot", int'(en_a), 1 << wdig);
            chk("segments", int'(seg_a), int'(exp_seg(wdig)));
            chk("dp", int'(dp_a), int'(exp_dp[wdig]));
         end else if (in_win) begin
            in_win = 0;
            chk("on_time", wlen, PRESCALE * wbright);
         end
         if (offn == 2) frame_bright = exp_bright;
         if (frame_done) begin
            chk("frame_period", offn, FRAME);
            chk("windows_per_frame", win_cnt, (frame_bright > 0) ? DIGITS : 0);
            win_cnt = 0;
            fcount++;
            while (sb.size() > 0 && sb[0].idx <= fcount) begin
               exp_val = sb[0].val;
               exp_dp  = sb[0].dp;
               void'(sb.pop_front());
            end
            off = 0;
         end else begin
            off = offn;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fd();
      int t;
      t = 0;
      while (!frame_done && t < 2 * FRAME + 10) begin
         step(1);
         t++;
      end
      chk("frame_done_seen", int'(frame_done), 1);
   endtask

   task automatic push_upd(input int idx, input logic [15:0] v, input logic [3:0] d);
      upd_t u;
      u.idx = idx; u.val = v; u.dp = d;
      sb.push_back(u);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ds_en", int'(ds_en), 4'hF);
      chk("rst_ds_reg", int'(ds_reg), 7'h7F);
      chk("rst_ds_dp", int'(ds_dp), 1);
      chk("rst_frame_done", int'(frame_done), 0);
   endtask

   // One frame of stimulus, entered one cycle after frame_done is seen
   task automatic run_frame(input int br, input bit bl, input bit do_mid, input int mpos,
                            input logic [15:0] mval, input logic [3:0] mdp,
                            input bit do_bnd, input logic [15:0] bval, input logic [3:0] bdp);
      bright = 4'(br); exp_bright = br;
      blank_lz = bl;   exp_blank = bl;
      if (do_mid) begin
         step(mpos - 1);
         num_in = mval; dp_in = mdp; load = 1'b1;
         push_upd(fcount + 1, mval, mdp);
         step(1);
         load = 1'b0;
         step(FRAME - 2 - mpos);
      end else begin
         step(FRAME - 2);
      end
      if (do_bnd) begin
         num_in = bval; dp_in = bdp; load = 1'b1;
         push_upd(fcount + 2, bval, bdp);
      end
      step(1);
      load = 1'b0;
      step(1);
   endtask

   // Mid-frame reset with data still pending in the shadow register
   task automatic run_reset_test();
      step(10);
      num_in = 16'hBEEF; dp_in = 4'hF; load = 1'b1;
      push_upd(fcount + 1, 16'hBEEF, 4'hF);
      step(1);
      load = 1'b0;
      step(30);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      sb.delete();
      exp_val = '0;
      exp_dp  = '0;
      step(4);
      chk_reset_outputs();
      rst_n = 1'b1;
      wait_fd();
      step(1);
   endtask

   // Stimulus: directed frames first, then randomized frames
   initial begin : stim
      int          br, mpos;
      bit          bl, do_mid, do_bnd;
      logic [15:0] mval, bval;
      logic [3:0]  mdp, bdp;
      bright = 4'd15; exp_bright = 15;
      step(3);
      chk_reset_outputs();
      rst_n = 1'b1;
      wait_fd();
      step(1);
      for (int i = 0; i < 26; i++) begin
         br = 15; bl = 0; do_mid = 0; mpos = 20; mval = '0; mdp = '0;
         do_bnd = 0; bval = '0; bdp = '0;
         case (i)
            0: begin do_mid = 1; mval = 16'h12AF; mdp = 4'b0001; end
            1: ;
            2: begin br = 4; bl = 1; do_mid = 1; mval = 16'h0050; mdp = 4'b0010; end
            3: begin br = 4; bl = 1; end
            4: begin br = 0; bl = 1; do_mid = 1; mpos = 60; mval = 16'h3333; mdp = 4'h0;
                     do_bnd = 1; bval = 16'h0C07; bdp = 4'b1000; end
            5: begin br = 7; bl = 1; end
            6: begin br = 9; bl = 0; end
            default: begin
               br     = $urandom_range(0, 15);
               bl     = 1'($urandom_range(0, 1));
               do_mid = 1'($urandom_range(0, 1));
               mpos   = $urandom_range(2, 120);
               mval   = 16'($urandom) >> (4 * $urandom_range(0, 3));
               mdp    = 4'($urandom);
               do_bnd = 1'($urandom_range(0, 1));
               bval   = 16'($urandom) >> (4 * $urandom_range(0, 3));
               bdp    = 4'($urandom);
            end
         endcase
         if (i == 16) run_reset_test();
         else run_frame(br, bl, do_mid, mpos, mval, mdp, do_bnd, bval, bdp);
      end
      step(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
